// File: rtl/tron_key_decoder_pkg.sv
// Shared types for the Tron keyboard front end.
// Directions, scancodes and the prefix-state encoding.
package tron_types;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_RIGHT = 2'd1,
    DIR_DOWN  = 2'd2,
    DIR_LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } pfx_state_t;

  localparam logic [7:0] KEY_W     = 8'h1D;
  localparam logic [7:0] KEY_S     = 8'h1B;
  localparam logic [7:0] KEY_A     = 8'h1C;
  localparam logic [7:0] KEY_D     = 8'h23;
  localparam logic [7:0] KEY_SPACE = 8'h29;
  localparam logic [7:0] KEY_UP    = 8'h75;
  localparam logic [7:0] KEY_DOWN  = 8'h72;
  localparam logic [7:0] KEY_LEFT  = 8'h6B;
  localparam logic [7:0] KEY_RIGHT = 8'h74;
  localparam logic [7:0] PFX_EXT   = 8'hE0;
  localparam logic [7:0] PFX_BRK   = 8'hF0;

  function automatic dir_t opposite(input dir_t d);
    dir_t o;
    unique case (d)
      DIR_UP:    o = DIR_DOWN;
      DIR_DOWN:  o = DIR_UP;
      DIR_LEFT:  o = DIR_RIGHT;
      default:   o = DIR_LEFT;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/tron_key_decoder_turn_queue.sv
// Per-player turn FIFO of directions.
// Exposes head and tail so the decoder can filter turns.
module turn_queue
  import tron_types::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          flush,
  input  logic          push,
  input  dir_t          din,
  input  logic          pop,
  output dir_t          head,
  output dir_t          tail,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  dir_t mem [DEPTH];

  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] last_ptr;
  logic          do_push;
  logic          do_pop;

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign last_ptr = wr_ptr - 1'b1;
  assign head     = mem[rd_ptr];
  assign tail     = mem[last_ptr];

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push)
        wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: only slots behind count are ever read.
  always_ff @(posedge clock) begin
    if (reset_n && !flush && do_push)
      mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tron_key_decoder.sv
// PS/2 scancode decoder producing per-player directions.
// Buffers turns per player and filters reversals and no-ops.
module tron_key_decoder
  import tron_types::*;
#(
  parameter int QUEUE_DEPTH = 2,
  localparam int CW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          ps2_code_new,
  input  logic [7:0]    ps2_code,
  input  logic          step,
  output dir_t          dir1,
  output dir_t          dir2,
  output logic          game_reset,
  output logic [CW-1:0] q1_count,
  output logic [CW-1:0] q2_count
);

  logic [1:0] sr;
  logic       code_valid;
  pfx_state_t state;

  logic restart;
  logic turn1;
  logic turn2;
  dir_t new_dir;

  dir_t q1_head, q1_tail;
  dir_t q2_head, q2_tail;
  logic q1_full, q1_empty;
  logic q2_full, q2_empty;

  dir_t ref1, ref2;
  logic push1, push2;
  logic pop1, pop2;

  assign code_valid = (sr == 2'b01);

  always_comb begin
    restart = 1'b0;
    turn1   = 1'b0;
    turn2   = 1'b0;
    new_dir = DIR_UP;
    if (code_valid) begin
      unique case (state)
        ST_IDLE: begin
          case (ps2_code)
            KEY_W:     begin turn1 = 1'b1; new_dir = DIR_UP;    end
            KEY_S:     begin turn1 = 1'b1; new_dir = DIR_DOWN;  end
            KEY_A:     begin turn1 = 1'b1; new_dir = DIR_LEFT;  end
            KEY_D:     begin turn1 = 1'b1; new_dir = DIR_RIGHT; end
            KEY_SPACE: restart = 1'b1;
            default:   ;
          endcase
        end
        ST_EXT: begin
          case (ps2_code)
            KEY_UP:    begin turn2 = 1'b1; new_dir = DIR_UP;    end
            KEY_DOWN:  begin turn2 = 1'b1; new_dir = DIR_DOWN;  end
            KEY_LEFT:  begin turn2 = 1'b1; new_dir = DIR_LEFT;  end
            KEY_RIGHT: begin turn2 = 1'b1; new_dir = DIR_RIGHT; end
            default:   ;
          endcase
        end
        default: ;
      endcase
    end
  end

  // Compare against the last queued turn, or the live direction if none.
  assign ref1 = q1_empty ? dir1 : q1_tail;
  assign ref2 = q2_empty ? dir2 : q2_tail;

  assign push1 = turn1 && !q1_full &&
                 (new_dir != ref1) &&
                 (new_dir != opposite(ref1));
  assign push2 = turn2 && !q2_full &&
                 (new_dir != ref2) &&
                 (new_dir != opposite(ref2));

  assign pop1 = step && !restart && !q1_empty;
  assign pop2 = step && !restart && !q2_empty;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else if (code_valid) begin
      unique case (1'b1)
        (ps2_code == PFX_EXT):
          state <= (state inside {ST_BRK, ST_EXT_BRK}) ?
                   ST_EXT_BRK : ST_EXT;
        (ps2_code == PFX_BRK):
          state <= (state inside {ST_EXT, ST_EXT_BRK}) ?
                   ST_EXT_BRK : ST_BRK;
        default:
          state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sr         <= 2'b00;
      dir1       <= DIR_RIGHT;
      dir2       <= DIR_LEFT;
      game_reset <= 1'b0;
    end else begin
      sr         <= {sr[0], ps2_code_new};
      game_reset <= restart;
      if (restart) begin
        dir1 <= DIR_RIGHT;
        dir2 <= DIR_LEFT;
      end else begin
        if (pop1)
          dir1 <= q1_head;
        if (pop2)
          dir2 <= q2_head;
      end
    end
  end

  turn_queue #(.DEPTH(QUEUE_DEPTH)) u_q1 (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (restart),
    .push    (push1),
    .din     (new_dir),
    .pop     (pop1),
    .head    (q1_head),
    .tail    (q1_tail),
    .count   (q1_count),
    .full    (q1_full),
    .empty   (q1_empty)
  );

  turn_queue #(.DEPTH(QUEUE_DEPTH)) u_q2 (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (restart),
    .push    (push2),
    .din     (new_dir),
    .pop     (pop2),
    .head    (q2_head),
    .tail    (q2_tail),
    .count   (q2_count),
    .full    (q2_full),
    .empty   (q2_empty)
  );

endmodule

// File: tb/tb_tron_key_decoder.sv
// Scoreboard bench for tron_key_decoder.
// Transaction-level model of keys, queues and steps.
module tb_tron_key_decoder;
  import tron_types::*;

  localparam int DEPTH = 2;
  localparam int CW = $clog2(DEPTH + 1);

  logic          clock;
  logic          reset_n;
  logic          ps2_code_new;
  logic [7:0]    ps2_code;
  logic          step;
  dir_t          dir1;
  dir_t          dir2;
  logic          game_reset;
  logic [CW-1:0] q1_count;
  logic [CW-1:0] q2_count;

  tron_key_decoder #(.QUEUE_DEPTH(DEPTH)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .ps2_code_new (ps2_code_new),
    .ps2_code     (ps2_code),
    .step         (step),
    .dir1         (dir1),
    .dir2         (dir2),
    .game_reset   (game_reset),
    .q1_count     (q1_count),
    .q2_count     (q2_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    dir_t d1;
    dir_t d2;
    int   q1;
    int   q2;
    int   gr;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   gr_seen = 0;

  dir_t m_d1, m_d2;
  dir_t mq1[$];
  dir_t mq2[$];
  bit   m_ext, m_brk;

  function automatic dir_t opp(input dir_t d);
    case (d)
      DIR_UP:    return DIR_DOWN;
      DIR_DOWN:  return DIR_UP;
      DIR_LEFT:  return DIR_RIGHT;
      default:   return DIR_LEFT;
    endcase
  endfunction

  function automatic bit turn_ok(input dir_t nd, input dir_t r, input int n);
    return (nd != r) && (nd != opp(r)) && (n < DEPTH);
  endfunction

  function automatic void chk(input string n, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endfunction

  always @(negedge clock) begin
    exp_t e;
    if (game_reset === 1'b1)
      gr_seen++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("dir1", int'(dir1), int'(e.d1));
      chk("dir2", int'(dir2), int'(e.d2));
      chk("q1_count", int'(q1_count), e.q1);
      chk("q2_count", int'(q2_count), e.q2);
      chk("game_reset_cycles", gr_seen, e.gr);
      gr_seen = 0;
    end
  end

  task automatic push_exp(input int gr);
    exp_t e;
    e.d1 = m_d1;
    e.d2 = m_d2;
    e.q1 = mq1.size();
    e.q2 = mq2.size();
    e.gr = gr;
    sb.push_back(e);
  endtask

  task automatic model_reset();
    m_d1 = DIR_RIGHT;
    m_d2 = DIR_LEFT;
    mq1.delete();
    mq2.delete();
    m_ext = 0;
    m_brk = 0;
  endtask

  task automatic model(input bit have, input logic [7:0] c,
                       input bit stp, output int gr);
    bit   rst = 0, t1 = 0, t2 = 0, a1, a2;
    dir_t nd = DIR_UP;
    dir_t r1, r2;
    if (have) begin
      if (c == PFX_EXT) m_ext = 1;
      else if (c == PFX_BRK) m_brk = 1;
      else begin
        if (!m_brk && !m_ext) begin
          case (c)
            8'h1D: begin t1 = 1; nd = DIR_UP;    end
            8'h1B: begin t1 = 1; nd = DIR_DOWN;  end
            8'h1C: begin t1 = 1; nd = DIR_LEFT;  end
            8'h23: begin t1 = 1; nd = DIR_RIGHT; end
            8'h29: rst = 1;
            default: ;
          endcase
        end else if (!m_brk) begin
          case (c)
            8'h75: begin t2 = 1; nd = DIR_UP;    end
            8'h72: begin t2 = 1; nd = DIR_DOWN;  end
            8'h6B: begin t2 = 1; nd = DIR_LEFT;  end
            8'h74: begin t2 = 1; nd = DIR_RIGHT; end
            default: ;
          endcase
        end
        m_ext = 0;
        m_brk = 0;
      end
    end
    r1 = (mq1.size() > 0) ? mq1[$] : m_d1;
    r2 = (mq2.size() > 0) ? mq2[$] : m_d2;
    a1 = t1 && turn_ok(nd, r1, mq1.size());
    a2 = t2 && turn_ok(nd, r2, mq2.size());
    gr = rst;
    if (rst) begin
      m_d1 = DIR_RIGHT;
      m_d2 = DIR_LEFT;
      mq1.delete();
      mq2.delete();
    end else begin
      if (stp && mq1.size() > 0) m_d1 = mq1.pop_front();
      if (stp && mq2.size() > 0) m_d2 = mq2.pop_front();
      if (a1) mq1.push_back(nd);
      if (a2) mq2.push_back(nd);
    end
  endtask

  // step (if requested) lands on the same edge that consumes the code
  task automatic send(input logic [7:0] c, input bit stp);
    int gr;
    @(negedge clock); #1;
    ps2_code = c;
    ps2_code_new = 1'b1;
    @(negedge clock); #1;
    step = stp;
    @(negedge clock); #1;
    step = 1'b0;
    repeat (2) @(negedge clock);
    #1 ps2_code_new = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    model(1'b1, c, stp, gr);
    push_exp(gr);
  endtask

  task automatic do_step();
    int gr;
    @(negedge clock); #1;
    step = 1'b1;
    @(negedge clock); #1;
    step = 1'b0;
    @(negedge clock); #1;
    model(1'b0, 8'h00, 1'b1, gr);
    push_exp(gr);
  endtask

  task automatic do_reset();
    @(negedge clock); #1;
    reset_n = 1'b0;
    ps2_code_new = 1'b0;
    step = 1'b0;
    repeat (2) @(negedge clock);
    #1 reset_n = 1'b1;
    model_reset();
    push_exp(0);
  endtask

  logic [7:0] pool [13] = '{8'hE0, 8'hE0, 8'hF0, 8'h1D, 8'h1B,
                            8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B,
                            8'h74, 8'h12, 8'h29};

  initial begin
    reset_n = 1'b0;
    ps2_code_new = 1'b0;
    ps2_code = 8'h00;
    step = 1'b0;
    model_reset();

    do_reset();

    send(8'h1D, 0);
    do_step();

    send(8'h1D, 0);
    send(8'h1C, 0);
    send(8'h1B, 0);
    do_step();
    do_step();

    send(8'hE0, 0); send(8'h74, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    send(8'hE0, 0); send(8'h75, 0);

    send(8'h75, 0);
    send(8'hE0, 0); send(8'h1D, 0);
    send(8'hF0, 0); send(8'h1D, 0);
    send(8'h1D, 0);

    send(8'h1C, 0);
    do_step();
    send(8'h1D, 0);
    send(8'h29, 1);

    send(8'h1D, 0);
    send(8'h1B, 1);
    send(8'h1C, 0);
    send(8'h1D, 1);

    send(8'hE0, 0);
    do_reset();
    send(8'h75, 0);

    for (int i = 0; i < 250; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 2) do_step();
      else send(pool[$urandom_range(0, 12)], ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clock);
    #1;
    if (sb.size() != 0) chk("sb_drain", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
